// File: rtl/chip8_pkg.sv
// Shared constants for the CHIP-8 memory subsystem: default geometry, the built-in
// hex font image and the read-FSM state encoding.
package chip8_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int PROTECT_TOP_DEF = 'h200;
  localparam int FONT_BASE_DEF   = 'h000;
  localparam int FONT_BYTES      = 80;
  localparam int FONT_IDX_W      = $clog2(FONT_BYTES);

  // Glyphs "0".."F", five rows each, left-aligned in the upper nibble.
  localparam logic [7:0] FONT_ROM [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RAM  = 2'd1,
    R_ACK  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/chip8_ram_dp.sv
// Simple 1R1W read-first RAM; power-up contents are the font image at FONT_BASE,
// zero elsewhere. Contents are never cleared by reset.
module chip8_ram_dp
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FONT_BASE = FONT_BASE_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata_p1
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DEPTH-1:0][7:0] image_t;

  function automatic image_t init_image();
    image_t img;
    img = '0;
    for (int i = 0; i < FONT_BYTES; i++) begin
      img[ADDR_W'(FONT_BASE + i)] = FONT_ROM[FONT_IDX_W'(i)];
    end
    return img;
  endfunction

  image_t mem = init_image();

  // Read and write share an edge; the non-blocking update makes a same-address read see the old byte.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_p1 <= mem[raddr];
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 main memory controller: read handshake FSM with re-arm guard, loader/CPU
// write arbitration with a one-entry CPU write buffer, and interpreter-area protection.
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int PROTECT_TOP = PROTECT_TOP_DEF,
  parameter int FONT_BASE   = FONT_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] mem_read_addr,
  output logic [7:0]        mem_read_data,
  output logic              mem_read_ack,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_write_addr,
  input  logic [7:0]        mem_write_data,
  input  logic              load_write,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              write_violation
);

  localparam logic [ADDR_W:0] PROT_LIMIT = (ADDR_W + 1)'(PROTECT_TOP);

  rd_state_t         state, state_nxt;
  logic              armed;
  logic [ADDR_W-1:0] last_addr;
  logic              accept;

  logic              buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              buf_load, buf_clear, drop;

  logic              cpu_prot, cpu_ok;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata_p1;

  assign cpu_prot = mem_write && ({1'b0, mem_write_addr} < PROT_LIMIT);
  assign cpu_ok   = mem_write && !cpu_prot;
  assign accept   = (state == R_IDLE) && mem_read && armed;

  // Single write port: loader first, then the buffered CPU byte, then a direct CPU write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mem_write_addr;
    ram_wdata = mem_write_data;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    drop      = 1'b0;
    if (load_write) begin
      ram_we    = 1'b1;
      ram_waddr = load_addr;
      ram_wdata = load_data;
      if (cpu_ok) begin
        if (buf_vld) drop = 1'b1;
        else         buf_load = 1'b1;
      end
    end else if (buf_vld) begin
      ram_we    = 1'b1;
      ram_waddr = buf_addr;
      ram_wdata = buf_data;
      if (cpu_ok) buf_load  = 1'b1;
      else        buf_clear = 1'b1;
    end else if (cpu_ok) begin
      ram_we = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      R_IDLE:  if (accept) state_nxt = R_RAM;
      R_RAM:   state_nxt = R_ACK;
      R_ACK:   state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= R_IDLE;
      armed           <= 1'b1;
      buf_vld         <= 1'b0;
      mem_read_ack    <= 1'b0;
      mem_read_data   <= 8'h00;
      write_violation <= 1'b0;
    end else begin
      state           <= state_nxt;
      mem_read_ack    <= (state == R_ACK);
      write_violation <= cpu_prot || drop;
      // A held request at the same address must not be served twice.
      if (state == R_ACK)                                    armed <= 1'b0;
      else if (!mem_read || (mem_read_addr != last_addr))   armed <= 1'b1;
      if (buf_load)       buf_vld <= 1'b1;
      else if (buf_clear) buf_vld <= 1'b0;
      if (state == R_ACK) mem_read_data <= ram_rdata_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) last_addr <= mem_read_addr;
    if (buf_load) begin
      buf_addr <= mem_write_addr;
      buf_data <= mem_write_data;
    end
  end

  // Stage p1: RAM output register, loaded at the end of the R_RAM cycle.
  chip8_ram_dp #(
    .ADDR_W    (ADDR_W),
    .FONT_BASE (FONT_BASE)
  ) u_ram (
    .clk      (clk),
    .we       (ram_we && !rst),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .re       (state == R_RAM),
    .raddr    (last_addr),
    .rdata_p1 (ram_rdata_p1)
  );

endmodule

// File: doc/chip8_mem_ctrl.md
Name: chip8_mem_ctrl

Overview:
- Main memory for the CHIP-8 core: 4096 x 8 RAM with one read port and one write port.
- Sits directly downstream of the CPU and serves its mem_read/mem_read_ack fetch handshake and its mem_write strobe.
- Also accepts a program-loader write stream, which has priority over CPU writes.
- Holds the built-in hex font at 0x000 and write-protects the interpreter area below 0x200 against CPU writes.

Parameters:
ADDR_W, 12, address width in bits; depth is 2**ADDR_W bytes.
PROTECT_TOP, 'h200, CPU writes to addresses below this are dropped.
FONT_BASE, 'h000, base address of the 80-byte font (16 glyphs x 5 bytes).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
mem_read  in  1  CPU read request, level; CPU holds it until ack
mem_read_addr  in  ADDR_W  CPU read address
mem_read_data  out  8  read data, valid in the ack cycle and held until the next ack
mem_read_ack  out  1  one-cycle pulse, read complete
mem_write  in  1  CPU write strobe, one byte per high cycle
mem_write_addr  in  ADDR_W  CPU write address
mem_write_data  in  8  CPU write data
load_write  in  1  loader write strobe
load_addr  in  ADDR_W  loader write address, no protection
load_data  in  8  loader write data
write_violation  out  1  one-cycle pulse: CPU write dropped (protected address or buffer overflow)

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high.
- Reset values: mem_read_ack=0, mem_read_data=0, write_violation=0, read FSM=R_IDLE, armed=1, write buffer empty.
- RAM contents are not cleared by rst.
- Power-up image: font bytes from the package at FONT_BASE; all other locations 0.

Read FSM (R_IDLE, R_RAM, R_ACK):
- R_IDLE -> R_RAM when mem_read=1 and armed=1. Latch the address into last_addr and issue the RAM read.
- R_RAM -> R_ACK: RAM data registered into mem_read_data.
- R_ACK: mem_read_ack=1 for exactly one cycle, then R_IDLE with armed=0.
- Latency: ack is asserted 2 cycles after the accepting edge.
- mem_read_addr is ignored after acceptance.
- Re-arm rule: armed returns to 1 on any cycle in which mem_read=0 or mem_read_addr != last_addr. This ensures a request the CPU holds high after ack is never acked twice.
- Acceptance requires armed=1 at the time of acceptance, so the re-arm cycle itself does not accept.
- Read/write collision: the RAM is read-first. A write to the same address on the RAM-read cycle returns the old byte.

Write path:
- Priority: loader write > buffered CPU write > direct CPU write.
- Loader write: committed on the same edge, at any address.
- CPU write with addr < PROTECT_TOP: dropped, write_violation pulses the next cycle.
- CPU write with addr >= PROTECT_TOP, RAM write port free: committed on the same edge.
- CPU write with addr >= PROTECT_TOP, loader writing that cycle: held in a 1-entry buffer, committed on the first cycle with no loader write.
- Buffer full and another unprotected CPU write arrives while the loader still holds the port: the new write is dropped and write_violation pulses. The buffered entry is kept.
- Buffer drains while a new CPU write arrives: the buffer commits, and the new write takes the buffer slot (FIFO order preserved).
- Addresses are ADDR_W bits with no wrap logic; the full range is valid.

Reset mid-operation:
- Pending read aborted with no ack.
- Buffered write discarded.
- Writes presented in the reset cycle are ignored.

Decomposition:
- chip8_pkg holds:
  - ADDR_W and PROTECT_TOP defaults
  - FONT_BASE, FONT_BYTES=80
  - FONT_ROM constant array of the 80 standard glyph bytes (0xF0,0x90,0x90,0x90,0xF0 for "0" ... "F")
  - read-state encodings
- One sub-module, chip8_ram_dp: a simple dual-port 1R1W read-first RAM with initial-image loading.
- Arbitration, write buffer and read FSM stay in chip8_mem_ctrl.

Test Plan:
- Font readback: read 0x000..0x004 -> data F0,90,90,90,F0; each ack exactly 2 cycles after acceptance.
- CPU-style fetch: hold mem_read=1 at 0x200 after ack, then switch to 0x201 -> exactly one ack per address, never a second ack at 0x200 while held.
- Protection: CPU writes 0x1FF=AA -> write_violation pulses, a 0x1FF read still returns the prior value. CPU writes 0x200=55 -> readback 55.
- Loader contention: loader writes 0x300=11 while CPU writes 0x301=22 in the same cycle, loader idle next cycle -> 0x300=11 and 0x301=22. A second CPU write while the loader stays busy -> write_violation.
- Read-first collision: read 0x250 (holds 0x01) while CPU writes 0x250=0x02 on the RAM-read cycle -> data 0x01, subsequent read returns 0x02.
- Reset mid-read: assert rst the cycle after acceptance -> no ack, mem_read_data=0. A fresh request then completes normally.
